// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-parallel deserialiser.
// Frame length grows by one bit when DEMUX_DESER8_PARITY_EN is defined.
package deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } deser_state_t;

  localparam int DEFAULT_WIDTH = 8;

`ifdef DEMUX_DESER8_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Bit-position counter for the deserialiser: wraps at TERMINAL, cleared by sync.
// A sync that coincides with a valid bit counts that bit as position 0.
module deser_bit_counter #(
  parameter int                CNT_W    = 3,
  parameter logic [CNT_W-1:0]  TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  assign terminal = (count == TERMINAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= advance ? CNT_W'(1) : '0;
    end else if (advance) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel converter with a double-buffered valid/ready output.
// Define DEMUX_DESER8_PARITY_EN for a trailing even-parity bit and out_perr.
module demux_deser8
  import deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEL_W     = $clog2(WIDTH + PARITY_BITS),
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
`ifdef DEMUX_DESER8_PARITY_EN
  , output logic           out_perr
`endif
);

  localparam int                FRAME = frame_len(WIDTH);
  localparam int                IDX_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0]  TERM  = SEL_W'(FRAME - 1);

  deser_state_t     state, state_next;
  logic [WIDTH-1:0] asm_q, asm_next;
  logic [SEL_W-1:0] wr_idx;
  logic [IDX_W-1:0] pos;
  logic             at_terminal;
  logic             complete;

  deser_bit_counter #(
    .CNT_W    (SEL_W),
    .TERMINAL (TERM)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (in_valid),
    .clear    (sync),
    .count    (sel),
    .terminal (at_terminal)
  );

  // A sync accompanied by a bit restarts the frame, so that bit is index 0.
  assign wr_idx   = sync ? '0 : sel;
  assign pos      = (LSB_FIRST != 0) ? IDX_W'(wr_idx)
                                     : IDX_W'(WIDTH - 1) - IDX_W'(wr_idx);
  assign complete = in_valid && !sync && at_terminal;

  always_comb begin
    asm_next = asm_q;
    if (in_valid && (int'(wr_idx) < WIDTH)) begin
      asm_next[pos] = in_bit;
    end
  end

  always_comb begin
    state_next = state;
    if (sync && !in_valid) begin
      state_next = IDLE;
    end else if (in_valid) begin
      state_next = complete ? IDLE : FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      asm_q <= '0;
    end else begin
      state <= state_next;
      asm_q <= asm_next;
    end
  end

  // A completed word loads only if the holding slot is free or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef DEMUX_DESER8_PARITY_EN
      out_perr  <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_word  <= asm_next;
          out_valid <= 1'b1;
`ifdef DEMUX_DESER8_PARITY_EN
          out_perr  <= (^asm_q) ^ in_bit;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Serial-to-parallel converter: the inverse of the 8:1 bit-select mux. The mux reads bit `i[s]` of a word; this block writes an incoming bit into position `sel` of a word.
- Assembles `WIDTH` serial bits into a parallel word and presents it on a valid/ready output.
- Double-buffered: a new word is assembled while the previous one waits for the consumer.
- Sits at the receive end of any bit-serial link driven by the mux selector.

Parameters:
- `WIDTH`, default 8: bits per word; must be at least 2.
- `SEL_W`, default 3: width of the bit index, equal to clog2(WIDTH).
- `LSB_FIRST`, default 1: 1 means the first bit lands in `word[0]`; 0 means it lands in `word[WIDTH-1]`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_bit`, input, 1: serial data bit.
- `in_valid`, input, 1: `in_bit` is accepted on this cycle. There is no backpressure on the input.
- `sync`, input, 1: frame alignment; forces the bit index back to 0.
- `sel`, output, SEL_W: index of the next bit position to be written.
- `out_word`, output, WIDTH: assembled word.
- `out_valid`, output, 1: `out_word` holds an unconsumed word.
- `out_ready`, input, 1: the consumer takes `out_word` on a cycle where `out_valid` and `out_ready` are both 1.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset:
  - `sel`=0, `out_word`=0, `out_valid`=0, `overrun`=0.
  - The assembly register is cleared and the FSM goes to IDLE.
  - Reset is effective mid-word; the partial word is discarded.
- FSM states:
  - IDLE: no bits collected.
  - FILL: 1 to WIDTH-1 bits collected.
  - Transitions:
    - IDLE to FILL on `in_valid`.
    - FILL to IDLE when the WIDTH-th bit is accepted.
    - Any state to IDLE on `sync` without `in_valid`.
- Bit write:
  - On `in_valid`, `asm[pos]` is set to `in_bit`.
  - `pos` = `sel` when `LSB_FIRST`=1; otherwise `pos` = WIDTH-1-`sel`.
  - `sel` then increments.
- Word completion:
  - Occurs when `in_valid` and `sel`=WIDTH-1.
  - On the next edge the full word (including this bit) moves to `out_word`, `out_valid` goes to 1 and `sel` wraps to 0.
  - Latency: `out_valid` rises 1 cycle after the last bit is accepted.
  - `asm` is not cleared between words; every position is overwritten before the next completion.
- Sync:
  - `sync` with `in_valid`: the partial word is discarded and `in_bit` is written as bit 0; `sel` becomes 1.
  - `sync` alone: `sel` becomes 0.
  - `sync` never affects `out_word` or `out_valid`.
- Output handshake:
  - `out_valid` stays high and `out_word` stays stable until `out_valid` and `out_ready` are both 1.
  - `out_valid` then drops on the next edge, unless a new word completes on the same cycle.
- Simultaneous completion and handshake: the new word loads and `out_valid` stays 1. No overrun.
- Completion while `out_valid`=1 and `out_ready`=0:
  - The new word is dropped; the held `out_word` is preserved.
  - `overrun`=1 for exactly one cycle.
  - `sel` still wraps to 0.
- `out_ready` is ignored when `out_valid`=0.

Optional Feature:
- Macro: `DEMUX_DESER8_PARITY_EN`.
- Defined:
  - Each frame is WIDTH+1 bits; the final bit is even parity over the data bits.
  - `sel` counts 0 to WIDTH, so it must be clog2(WIDTH+1) wide.
  - Completion occurs on the parity bit; the parity bit is not stored in `out_word`.
  - Added output `out_perr` (1 bit) is registered alongside `out_word`, is 1 when parity mismatches, and follows the same hold and drop rules as `out_word`. Reset value 0.
- Undefined: frames are WIDTH bits and there is no `out_perr` port.

Decomposition:
- Shared package `deser_pkg` holds:
  - the FSM state typedef (IDLE, FILL);
  - the default WIDTH constant;
  - the parity-length helper constant.
- One sub-module, `deser_bit_counter`:
  - holds the `sel` counter with wrap at a parameterised terminal count and the sync clear;
  - outputs a terminal-count flag.
- The output holding register and handshake stay in the top level.

Test Plan:
- Basic word: LSB_FIRST=1; send bits 1,0,1,1,0,0,1,0 on consecutive cycles with `out_ready`=1. Expect `out_word`=8'h4D with `out_valid` high for 1 cycle, starting 1 cycle after the last bit.
- MSB-first: LSB_FIRST=0, same bit stream. Expect `out_word`=8'hB2.
- Backpressure:
  - Hold `out_ready`=0; send word 8'hA5 then 8'h3C. Expect `out_word` stays 8'hA5, one `overrun` pulse on 8'h3C completion, `sel`=0.
  - Raise `out_ready`. Expect `out_valid` drops next cycle.
- Simultaneous: complete 8'h12 while 8'hFF is held and `out_ready`=1 that cycle. Expect `out_word`=8'h12, `out_valid` stays 1, `overrun`=0.
- Sync/reset mid-word:
  - After 3 bits, `sync` with `in_valid`. Expect `sel`=1, and the word completes 7 bits later.
  - Assert `rst_n`=0 asynchronously after 5 bits. Expect all outputs 0 immediately.
- Parity (macro defined): send 8'h07 followed by parity bit 1. Expect `out_word`=8'h07, `out_perr`=0. Repeat with parity bit 0. Expect `out_perr`=1.
